// File: rtl/throughout_monitor.sv
// Multi-channel on-chip checker: a rising edge of a implies d throughout
// (##1 b repeated MIN_CNT..MAX_CNT times ##1 c), with timeout and statistics.
module throughout_monitor #(
    parameter int NUM_CH  = 4,
    parameter int MIN_CNT = 2,
    parameter int MAX_CNT = 4,
    parameter int MODE    = 0,
    parameter int TIMEOUT = 16,
    parameter int STAT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     a,
    input  logic [NUM_CH-1:0]     b,
    input  logic [NUM_CH-1:0]     c,
    input  logic [NUM_CH-1:0]     d,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     pass,
    output logic [NUM_CH-1:0]     fail,
    output logic [2*NUM_CH-1:0]   fail_code,
    output logic [NUM_CH-1:0]     overlap,
    output logic [STAT_W-1:0]     pass_cnt,
    output logic [STAT_W-1:0]     fail_cnt
);

    localparam int BW = $clog2(MAX_CNT + 2);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CW = $clog2(NUM_CH + 1);
    localparam int SW = ((STAT_W > CW) ? STAT_W : CW) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        COUNT = 2'd2
    } state_t;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [BW-1:0]     bcnt_q  [NUM_CH];
    logic [BW-1:0]     bcnt_d  [NUM_CH];
    logic [TW-1:0]     tcnt_q  [NUM_CH];
    logic [TW-1:0]     tcnt_d  [NUM_CH];
    logic [NUM_CH-1:0] a_prev_q;
    logic [NUM_CH-1:0] b_prev_q, b_prev_d;
    logic [NUM_CH-1:0] busy_d, pass_d, fail_d, ovl_d;
    logic [2*NUM_CH-1:0] code_d;
    logic [CW-1:0]     pass_pop, fail_pop;
    logic              trig;
    logic              in_range;

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] cur,
                                                  input logic [CW-1:0]     inc);
        logic [SW-1:0] sum;
        sum = SW'(cur) + SW'(inc);
        if (sum > SW'({STAT_W{1'b1}}))
            return {STAT_W{1'b1}};
        return sum[STAT_W-1:0];
    endfunction

    always_comb begin
        busy_d   = '0;
        pass_d   = '0;
        fail_d   = '0;
        code_d   = '0;
        ovl_d    = overlap;
        b_prev_d = b_prev_q;
        pass_pop = '0;
        fail_pop = '0;
        trig     = 1'b0;
        in_range = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            bcnt_d[i]  = bcnt_q[i];
            tcnt_d[i]  = tcnt_q[i];
            trig       = a[i] & ~a_prev_q[i];
            in_range   = (32'(bcnt_q[i]) >= MIN_CNT) && (32'(bcnt_q[i]) <= MAX_CNT);

            case (state_q[i])
                IDLE: ;
                DELAY: begin
                    if (!d[i]) begin
                        fail_d[i]          = 1'b1;
                        code_d[2*i +: 2]   = 2'd1;
                    end else begin
                        state_d[i] = COUNT;
                    end
                end
                COUNT: begin
                    if (!d[i]) begin
                        fail_d[i]        = 1'b1;
                        code_d[2*i +: 2] = 2'd1;
                    end else if (c[i] && in_range && (MODE == 0 || b_prev_q[i])) begin
                        pass_d[i] = 1'b1;
                    end else if (b[i] && (32'(bcnt_q[i]) == MAX_CNT)) begin
                        fail_d[i]        = 1'b1;
                        code_d[2*i +: 2] = 2'd2;
                    end else if ((TIMEOUT != 0) && ((32'(tcnt_q[i]) + 1) == TIMEOUT)) begin
                        fail_d[i]        = 1'b1;
                        code_d[2*i +: 2] = 2'd3;
                    end else begin
                        bcnt_d[i]   = bcnt_q[i] + BW'(b[i]);
                        b_prev_d[i] = b[i];
                        tcnt_d[i]   = tcnt_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = IDLE;
            endcase

            if (pass_d[i] || fail_d[i])
                state_d[i] = IDLE;

            // A trigger on the completing cycle starts the next attempt immediately
            if (trig) begin
                if (state_q[i] == IDLE || pass_d[i] || fail_d[i]) begin
                    state_d[i]  = DELAY;
                    bcnt_d[i]   = '0;
                    tcnt_d[i]   = '0;
                    b_prev_d[i] = 1'b0;
                end else begin
                    ovl_d[i] = 1'b1;
                end
            end

            busy_d[i] = (state_d[i] != IDLE);
            pass_pop  = pass_pop + CW'(pass_d[i]);
            fail_pop  = fail_pop + CW'(fail_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                bcnt_q[i]  <= '0;
                tcnt_q[i]  <= '0;
            end
            a_prev_q  <= '0;
            b_prev_q  <= '0;
            busy      <= '0;
            pass      <= '0;
            fail      <= '0;
            fail_code <= '0;
            overlap   <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                bcnt_q[i]  <= bcnt_d[i];
                tcnt_q[i]  <= tcnt_d[i];
            end
            a_prev_q  <= a;
            b_prev_q  <= b_prev_d;
            busy      <= busy_d;
            pass      <= pass_d;
            fail      <= fail_d;
            fail_code <= code_d;
            overlap   <= ovl_d;
            pass_cnt  <= sat_add(pass_cnt, pass_pop);
            fail_cnt  <= sat_add(fail_cnt, fail_pop);
        end
    end

endmodule

// File: tb/tb_throughout_monitor.sv
// Directed bench for throughout_monitor: three instances (defaults, goto mode,
// short timeout with 2-bit statistics) sharing b/c/d with separate triggers.
module tb_throughout_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a_def = '0, a_m1 = '0, a_to = '0;
    logic [3:0] b = '0, c = '0, d = '0;

    logic [3:0]  busy_def, pass_def, fail_def, ovl_def;
    logic [7:0]  code_def;
    logic [15:0] pcnt_def, fcnt_def;
    logic [3:0]  busy_m1, pass_m1, fail_m1, ovl_m1;
    logic [7:0]  code_m1;
    logic [15:0] pcnt_m1, fcnt_m1;
    logic [3:0]  busy_to, pass_to, fail_to, ovl_to;
    logic [7:0]  code_to;
    logic [1:0]  pcnt_to, fcnt_to;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    throughout_monitor dut_def (
        .clk(clk), .rst_n(rst_n), .a(a_def), .b(b), .c(c), .d(d),
        .busy(busy_def), .pass(pass_def), .fail(fail_def), .fail_code(code_def),
        .overlap(ovl_def), .pass_cnt(pcnt_def), .fail_cnt(fcnt_def)
    );

    throughout_monitor #(.MODE(1)) dut_m1 (
        .clk(clk), .rst_n(rst_n), .a(a_m1), .b(b), .c(c), .d(d),
        .busy(busy_m1), .pass(pass_m1), .fail(fail_m1), .fail_code(code_m1),
        .overlap(ovl_m1), .pass_cnt(pcnt_m1), .fail_cnt(fcnt_m1)
    );

    throughout_monitor #(.TIMEOUT(4), .STAT_W(2)) dut_to (
        .clk(clk), .rst_n(rst_n), .a(a_to), .b(b), .c(c), .d(d),
        .busy(busy_to), .pass(pass_to), .fail(fail_to), .fail_code(code_to),
        .overlap(ovl_to), .pass_cnt(pcnt_to), .fail_cnt(fcnt_to)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        tick(); tick();
        check("rst busy_def", 32'(busy_def), 0);
        check("rst pass_def", 32'(pass_def), 0);
        check("rst fail_def", 32'(fail_def), 0);
        check("rst code_def", 32'(code_def), 0);
        check("rst ovl_def",  32'(ovl_def), 0);
        check("rst pcnt_def", 32'(pcnt_def), 0);
        check("rst fcnt_def", 32'(fcnt_def), 0);
        check("rst busy_m1",  32'(busy_m1), 0);
        check("rst pass_m1",  32'(pass_m1), 0);
        check("rst fail_m1",  32'(fail_m1), 0);
        check("rst code_m1",  32'(code_m1), 0);
        check("rst ovl_m1",   32'(ovl_m1), 0);
        check("rst pcnt_m1",  32'(pcnt_m1), 0);
        check("rst fcnt_m1",  32'(fcnt_m1), 0);
        check("rst busy_to",  32'(busy_to), 0);
        check("rst pass_to",  32'(pass_to), 0);
        check("rst fail_to",  32'(fail_to), 0);
        check("rst code_to",  32'(code_to), 0);
        check("rst ovl_to",   32'(ovl_to), 0);
        check("rst pcnt_to",  32'(pcnt_to), 0);
        check("rst fcnt_to",  32'(fcnt_to), 0);
        rst_n = 1'b1;
        tick();

        // basic pass: b at 2 and 4, c at 5
        a_def = 4'b0001; d = 4'b0000; tick();          // e0
        check("basic busy e0", 32'(busy_def), 32'h1);
        d = 4'b0001; tick();                            // e1
        b = 4'b0001; tick();                            // e2
        b = 4'b0000; tick();                            // e3
        b = 4'b0001; tick();                            // e4
        check("basic pass e4", 32'(pass_def), 0);
        check("basic busy e4", 32'(busy_def), 32'h1);
        b = 4'b0000; c = 4'b0001; tick();               // e5
        check("basic pass e5", 32'(pass_def), 32'h1);
        check("basic busy e5", 32'(busy_def), 0);
        check("basic pcnt",    32'(pcnt_def), 1);
        c = 4'b0000; a_def = 4'b0000; tick();
        check("basic pass low", 32'(pass_def), 0);

        // d dropped during DELAY
        a_def = 4'b0001; d = 4'b0000; tick();           // e0
        tick();                                         // e1
        check("delay fail", 32'(fail_def), 32'h1);
        check("delay code", 32'(code_def), 32'h1);
        check("delay busy", 32'(busy_def), 0);
        check("delay fcnt", 32'(fcnt_def), 1);
        a_def = 4'b0000; tick();
        check("delay fail low", 32'(fail_def), 0);
        check("delay code low", 32'(code_def), 0);

        // early c with bcnt=1 is ignored, later c completes
        a_def = 4'b0001; tick();                        // e0
        d = 4'b0001; tick();                            // e1
        b = 4'b0001; tick();                            // e2
        b = 4'b0000; c = 4'b0001; tick();               // e3
        check("early pass", 32'(pass_def), 0);
        check("early busy", 32'(busy_def), 32'h1);
        check("early fail", 32'(fail_def), 0);
        c = 4'b0000; b = 4'b0001; tick();               // e4
        b = 4'b0000; c = 4'b0001; tick();               // e5
        check("late pass", 32'(pass_def), 32'h1);
        check("late pcnt", 32'(pcnt_def), 2);
        c = 4'b0000; a_def = 4'b0000; tick();

        // b overrun: five b at edges 2..6
        a_def = 4'b0001; tick();                        // e0
        d = 4'b0001; tick();                            // e1
        b = 4'b0001;
        tick(); tick(); tick(); tick();                 // e2..e5
        check("ovr fail e5", 32'(fail_def), 0);
        check("ovr busy e5", 32'(busy_def), 32'h1);
        tick();                                         // e6
        check("ovr fail e6", 32'(fail_def), 32'h1);
        check("ovr code e6", 32'(code_def), 32'h2);
        check("ovr fcnt",    32'(fcnt_def), 2);
        b = 4'b0000; a_def = 4'b0000; tick();

        // timeout (TIMEOUT=4)
        a_to = 4'b0001; tick();                         // e0
        d = 4'b0001;
        tick(); tick(); tick(); tick();                 // e1..e4
        check("to fail e4", 32'(fail_to), 0);
        check("to busy e4", 32'(busy_to), 32'h1);
        tick();                                         // e5
        check("to fail e5", 32'(fail_to), 32'h1);
        check("to code e5", 32'(code_to), 32'h3);
        a_to = 4'b0000; tick();

        // goto mode: c needs b in the previous cycle
        a_m1 = 4'b0001; tick();                         // e0
        d = 4'b0001; tick();                            // e1
        b = 4'b0001; tick();                            // e2
        tick();                                         // e3
        b = 4'b0000; tick();                            // e4
        c = 4'b0001; tick();                            // e5
        check("m1 pass e5", 32'(pass_m1), 0);
        check("m1 busy e5", 32'(busy_m1), 32'h1);
        c = 4'b0000; b = 4'b0001; tick();               // e6
        b = 4'b0000; c = 4'b0001; tick();               // e7
        check("m1 pass e7", 32'(pass_m1), 32'h1);
        check("m1 pcnt",    32'(pcnt_m1), 1);
        c = 4'b0000; a_m1 = 4'b0000; tick();

        // retrigger on the completing edge, then overlap mid-COUNT
        a_def = 4'b0001; tick();                        // e0
        a_def = 4'b0000; d = 4'b0001; tick();           // e1
        b = 4'b0001; tick();                            // e2
        tick();                                         // e3
        b = 4'b0000; c = 4'b0001; a_def = 4'b0001; tick(); // e4
        check("retrig pass", 32'(pass_def), 32'h1);
        check("retrig busy", 32'(busy_def), 32'h1);
        c = 4'b0000; tick();                            // e5
        check("retrig pass low", 32'(pass_def), 0);
        check("retrig busy e5",  32'(busy_def), 32'h1);
        a_def = 4'b0000; tick();                        // e6
        check("ovl clear", 32'(ovl_def), 0);
        a_def = 4'b0001; tick();                        // e7
        check("ovl set",     32'(ovl_def), 32'h1);
        check("ovl busy",    32'(busy_def), 32'h1);
        b = 4'b0001; tick(); tick();                    // e8, e9
        b = 4'b0000; c = 4'b0001; tick();               // e10
        check("ovl pass",  32'(pass_def), 32'h1);
        check("ovl pcnt",  32'(pcnt_def), 4);
        check("ovl stick", 32'(ovl_def), 32'h1);
        c = 4'b0000; a_def = 4'b0000; tick();

        // all four channels fail together
        a_def = 4'hF; d = 4'h0; tick();
        tick();
        check("multi fail", 32'(fail_def), 32'hF);
        check("multi code", 32'(code_def), 32'h55);
        check("multi fcnt", 32'(fcnt_def), 6);
        a_def = 4'h0; tick();

        // 2-bit statistics saturate
        a_to = 4'hF; tick(); tick();
        check("sat fail",  32'(fail_to), 32'hF);
        check("sat fcnt1", 32'(fcnt_to), 3);
        a_to = 4'h0; tick();
        a_to = 4'hF; tick(); tick();
        check("sat fcnt2", 32'(fcnt_to), 3);
        check("sat pcnt",  32'(pcnt_to), 0);
        a_to = 4'h0; tick();

        // reset mid-attempt, then trigger on release with a held high
        a_def = 4'b0001; d = 4'b0001; tick(); tick(); tick();
        check("pre-rst busy", 32'(busy_def), 32'h1);
        rst_n = 1'b0; d = 4'b0000; tick();
        check("mrst busy", 32'(busy_def), 0);
        check("mrst fail", 32'(fail_def), 0);
        check("mrst ovl",  32'(ovl_def), 0);
        check("mrst pcnt", 32'(pcnt_def), 0);
        check("mrst fcnt", 32'(fcnt_def), 0);
        rst_n = 1'b1; tick();
        check("rel busy", 32'(busy_def), 32'h1);
        tick();
        check("rel fail", 32'(fail_def), 32'h1);
        check("rel code", 32'(code_def), 32'h1);
        check("rel fcnt", 32'(fcnt_def), 1);
        a_def = 4'b0000; tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
